proc_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares the single UART transmitter among NUM_UNITS processing units of the scalable processor array.
- Each unit posts one result byte.
- The arbiter grants one unit at a time and emits a 2-byte frame (unit index, then data byte) over a valid/ready byte stream into the UART TX.
- Sits between the processing-unit array and the UART transmitter, in the CLK domain.

---
 rtl/proc_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_proc_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream among NUM_UNITS requesters.
// Each grant emits a 2-byte frame: unit index, then that unit's data byte.
module proc_tx_arbiter #(
   parameter int NUM_UNITS = 150,
   parameter int IDX_WIDTH = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_UNITS-1:0]   REQ_STB,
   input  logic [8*NUM_UNITS-1:0] REQ_DAT,
   output logic [NUM_UNITS-1:0]   REQ_ACK,
   output logic                   TX_STB,
   output logic [7:0]             TX_DAT,
   input  logic                   TX_RDY,
   output logic                   BUSY,
   output logic [IDX_WIDTH-1:0]   GRANT_IDX
);

   typedef enum logic [1:0] {IDLE, HDR, DAT} state_e;

   localparam logic [IDX_WIDTH-1:0] LAST_RST = IDX_WIDTH'(NUM_UNITS - 1);

   state_e               state_q, state_d;
   logic [IDX_WIDTH-1:0] last_q, last_d;
   logic [IDX_WIDTH-1:0] grant_q, grant_d;
   logic [7:0]           data_q, data_d;
   logic [7:0]           tx_dat_q, tx_dat_d;
   logic [NUM_UNITS-1:0] ack_q, ack_d;
   logic                 tx_stb_q, tx_stb_d;
   logic                 busy_q, busy_d;

   logic [NUM_UNITS-1:0]                last_bit, mask_hi, req_hi, cand, onehot;
   logic [IDX_WIDTH-1:0][NUM_UNITS-1:0] idx_bits;
   logic [7:0][NUM_UNITS-1:0]           dat_bits;
   logic [IDX_WIDTH-1:0]                pick_idx;
   logic [7:0]                          pick_dat;

   // Requests strictly above LAST win; otherwise wrap to the lowest set bit overall.
   assign last_bit = NUM_UNITS'(1) << last_q;
   assign mask_hi  = ~(last_bit | (last_bit - NUM_UNITS'(1)));
   assign req_hi   = REQ_STB & mask_hi;
   assign cand     = (|req_hi) ? req_hi : REQ_STB;
   assign onehot   = cand & (~cand + NUM_UNITS'(1));

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
      for (genvar b = 0; b < IDX_WIDTH; b++) begin : g_idx
         assign idx_bits[b][u] = onehot[u] & (((u >> b) & 1) == 1);
      end
      for (genvar j = 0; j < 8; j++) begin : g_dat
         assign dat_bits[j][u] = onehot[u] & REQ_DAT[8*u + j];
      end
   end

   for (genvar b = 0; b < IDX_WIDTH; b++) begin : g_idx_or
      assign pick_idx[b] = |idx_bits[b];
   end

   for (genvar j = 0; j < 8; j++) begin : g_dat_or
      assign pick_dat[j] = |dat_bits[j];
   end

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      last_d   = last_q;
      grant_d  = grant_q;
      data_d   = data_q;
      tx_dat_d = tx_dat_q;
      tx_stb_d = tx_stb_q;
      busy_d   = busy_q;
      ack_d    = '0;
      case (state_q)
         IDLE: begin
            if (|REQ_STB) begin
               ack_d    = onehot;
               data_d   = pick_dat;
               grant_d  = pick_idx;
               tx_stb_d = 1'b1;
               tx_dat_d = 8'(pick_idx);
               busy_d   = 1'b1;
               state_d  = HDR;
            end
         end
         HDR: begin
            if (TX_RDY) begin
               tx_dat_d = data_q;
               state_d  = DAT;
            end
         end
         DAT: begin
            if (TX_RDY) begin
               tx_stb_d = 1'b0;
               busy_d   = 1'b0;
               last_d   = grant_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops sample together.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= IDLE;
         last_q   <= LAST_RST;
         grant_q  <= '0;
         data_q   <= '0;
         tx_dat_q <= '0;
         tx_stb_q <= 1'b0;
         busy_q   <= 1'b0;
         ack_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         tx_dat_q <= tx_dat_d;
         tx_stb_q <= tx_stb_d;
         busy_q   <= busy_d;
         ack_q    <= ack_d;
      end
   end

   assign REQ_ACK   = ack_q;
   assign TX_STB    = tx_stb_q;
   assign TX_DAT    = tx_dat_q;
   assign BUSY      = busy_q;
   assign GRANT_IDX = grant_q;

endmodule

// File: tb/tb_proc_tx_arbiter.sv
// Bench for proc_tx_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a frame-level round-robin model.
module tb_proc_tx_arbiter;

   localparam int N  = 150;
   localparam int IW = 8;

   logic           CLK, RST, TX_RDY, TX_STB, BUSY;
   logic [N-1:0]   REQ_STB, REQ_ACK;
   logic [8*N-1:0] REQ_DAT;
   logic [7:0]     TX_DAT;
   logic [IW-1:0]  GRANT_IDX;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       rst_n;
      int         req_a;
      int         req_b;
      logic       rdy;
      int         exp_ack;
      logic       exp_stb;
      logic [7:0] exp_dat;
      logic       exp_busy;
      int         exp_grant;
   } vec_t;

   vec_t vecs[15];

   int         pend[N];
   int         sent[N];
   int         ack_cnt[N];
   bit         active[N];
   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   int         model_last;
   int         cur_grant;

   proc_tx_arbiter #(.NUM_UNITS(N), .IDX_WIDTH(IW)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ_STB  (REQ_STB),
      .REQ_DAT  (REQ_DAT),
      .REQ_ACK  (REQ_ACK),
      .TX_STB   (TX_STB),
      .TX_DAT   (TX_DAT),
      .TX_RDY   (TX_RDY),
      .BUSY     (BUSY),
      .GRANT_IDX(GRANT_IDX)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] dir_dat(input int i);
      return (i == 5) ? 8'hA7 : 8'(i * 3 + 1);
   endfunction

   function automatic logic [7:0] byte_of(input int u, input int s);
      return 8'(u * 37 + s * 101 + 11);
   endfunction

   function automatic logic [N-1:0] unit_vec(input int u);
      return (u < 0) ? '0 : (N'(1) << u);
   endfunction

   // Round robin: first requester found walking last+1, last+2, ... modulo N.
   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int u;
         u = (last + k) % N;
         if (req[u]) return u;
      end
      return -1;
   endfunction

   function automatic vec_t mk(input logic rst_n, input int a, input int b, input logic rdy,
                               input int ack, input logic stb, input logic [7:0] dat,
                               input logic busy, input int grant);
      vec_t v;
      v.rst_n = rst_n; v.req_a = a; v.req_b = b; v.rdy = rdy; v.exp_ack = ack;
      v.exp_stb = stb; v.exp_dat = dat; v.exp_busy = busy; v.exp_grant = grant;
      return v;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst_n, input logic [N-1:0] req, input logic rdy);
      RST     = rst_n;
      REQ_STB = req;
      TX_RDY  = rdy;
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_out(input string tag, input int ack, input logic stb,
                             input logic [7:0] dat, input logic chk_dat,
                             input logic busy, input int grant);
      check({tag, "_ack"}, 256'(REQ_ACK), 256'(unit_vec(ack)));
      check({tag, "_stb"}, 256'(TX_STB), 256'(stb));
      if (chk_dat) check({tag, "_dat"}, 256'(TX_DAT), 256'(dat));
      check({tag, "_busy"}, 256'(BUSY), 256'(busy));
      check({tag, "_grant"}, 256'(GRANT_IDX), 256'(grant));
   endtask

   task automatic do_reset();
      step(1'b0, '0, 1'b1);
      model_last = N - 1;
      cur_grant  = 0;
      exp_q.delete();
      rx_log.delete();
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; sent[i] = 0; ack_cnt[i] = 0; active[i] = 1'b0;
      end
   endtask

   // Requesters present bytes from pend[]; the model predicts grants and the
   // exact byte sequence at frame level and compares every cycle.
   task automatic run_traffic(input int act_mod, input bit rand_rdy, input int max_cycles);
      logic [N-1:0] req_drv, ack_exp;
      logic         rdy_drv;
      int           g, cyc;
      bit           was_idle, done, any_pend;
      cyc  = 0;
      done = 1'b0;
      while (!done) begin
         for (int i = 0; i < N; i++) begin
            if (pend[i] > 0 && !active[i] && $urandom_range(0, act_mod) == 0) active[i] = 1'b1;
            req_drv[i] = active[i];
            REQ_DAT[8*i +: 8] = active[i] ? byte_of(i, sent[i]) : 8'($urandom);
         end
         rdy_drv = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (TX_STB && rdy_drv) rx_log.push_back(TX_DAT);
         step(1'b1, req_drv, rdy_drv);

         was_idle = (exp_q.size() == 0);
         ack_exp  = '0;
         if (!was_idle && rdy_drv) begin
            if (exp_q.size() == 1) model_last = cur_grant;
            void'(exp_q.pop_front());
         end else if (was_idle && req_drv != '0) begin
            g         = rr_pick(req_drv, model_last);
            ack_exp   = unit_vec(g);
            cur_grant = g;
            exp_q.push_back(8'(g));
            exp_q.push_back(byte_of(g, sent[g]));
         end

         check("rt_ack", 256'(REQ_ACK), 256'(ack_exp));
         check("rt_busy", 256'(BUSY), 256'(exp_q.size() != 0));
         check("rt_stb", 256'(TX_STB), 256'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("rt_dat", 256'(TX_DAT), 256'(exp_q[0]));
         check("rt_grant", 256'(GRANT_IDX), 256'(cur_grant));

         any_pend = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (REQ_ACK[i]) begin
               active[i] = 1'b0; pend[i]--; sent[i]++; ack_cnt[i]++;
            end
            if (pend[i] > 0) any_pend = 1'b1;
         end
         cyc++;
         done = !any_pend && (exp_q.size() == 0);
         if (!done && cyc >= max_cycles) begin
            checks++;
            failures++;
            $display("FAIL rt_timeout: traffic not drained after %0d cycles", cyc);
            done = 1'b1;
         end
      end
      if (TX_STB && rdy_drv) rx_log.push_back(TX_DAT);
   endtask

   initial begin
      int bad, total;
      RST     = 1'b0;
      REQ_STB = '0;
      TX_RDY  = 1'b1;
      for (int i = 0; i < N; i++) REQ_DAT[8*i +: 8] = dir_dat(i);

      // Single request from unit 5, then rotation with wrap between units 0 and 149.
      vecs[0]  = mk(0, -1,  -1, 1,  -1, 0, 8'h00,        0, 0);
      vecs[1]  = mk(1,  5,  -1, 1,   5, 1, 8'h05,        1, 5);
      vecs[2]  = mk(1, -1,  -1, 1,  -1, 1, 8'hA7,        1, 5);
      vecs[3]  = mk(1, -1,  -1, 1,  -1, 0, 8'h00,        0, 5);
      vecs[4]  = mk(1, -1,  -1, 1,  -1, 0, 8'h00,        0, 5);
      vecs[5]  = mk(0, -1,  -1, 1,  -1, 0, 8'h00,        0, 0);
      vecs[6]  = mk(1,  0, 149, 1,   0, 1, 8'h00,        1, 0);
      vecs[7]  = mk(1,  0, 149, 1,  -1, 1, dir_dat(0),   1, 0);
      vecs[8]  = mk(1,  0, 149, 1,  -1, 0, 8'h00,        0, 0);
      vecs[9]  = mk(1,  0, 149, 1, 149, 1, 8'd149,       1, 149);
      vecs[10] = mk(1,  0, 149, 1,  -1, 1, dir_dat(149), 1, 149);
      vecs[11] = mk(1,  0, 149, 1,  -1, 0, 8'h00,        0, 149);
      vecs[12] = mk(1,  0, 149, 1,   0, 1, 8'h00,        1, 0);
      vecs[13] = mk(1, -1,  -1, 1,  -1, 1, dir_dat(0),   1, 0);
      vecs[14] = mk(1, -1,  -1, 1,  -1, 0, 8'h00,        0, 0);

      for (int r = 0; r < 15; r++) begin
         step(vecs[r].rst_n, unit_vec(vecs[r].req_a) | unit_vec(vecs[r].req_b), vecs[r].rdy);
         expect_out($sformatf("row%0d", r), vecs[r].exp_ack, vecs[r].exp_stb, vecs[r].exp_dat,
                    vecs[r].exp_stb || !vecs[r].rst_n, vecs[r].exp_busy, vecs[r].exp_grant);
      end

      // Back-pressure in HDR then DAT; unit 9 requests throughout and must not be acked.
      step(1, unit_vec(5), 1);
      expect_out("bp_grant", 5, 1, 8'h05, 1, 1, 5);
      for (int i = 0; i < 10; i++) begin
         step(1, unit_vec(9), 0);
         expect_out("bp_hdr", -1, 1, 8'h05, 1, 1, 5);
      end
      step(1, unit_vec(9), 1);
      expect_out("bp_hdr_go", -1, 1, 8'hA7, 1, 1, 5);
      for (int i = 0; i < 10; i++) begin
         step(1, unit_vec(9), 0);
         expect_out("bp_dat", -1, 1, 8'hA7, 1, 1, 5);
      end
      step(1, '0, 1);
      expect_out("bp_done", -1, 0, 8'h00, 0, 0, 5);
      step(1, '0, 1);
      expect_out("bp_idle", -1, 0, 8'h00, 0, 0, 5);

      // Reset while in DAT; afterwards unit 3 beats unit 10 because priority restarts at 0.
      step(1, unit_vec(10), 1);
      expect_out("rst_grant", 10, 1, 8'h0A, 1, 1, 10);
      step(1, '0, 1);
      expect_out("rst_hdr", -1, 1, dir_dat(10), 1, 1, 10);
      step(0, unit_vec(3) | unit_vec(10), 0);
      expect_out("rst_mid", -1, 0, 8'h00, 1, 0, 0);
      step(1, unit_vec(3) | unit_vec(10), 1);
      expect_out("rst_regrant", 3, 1, 8'h03, 1, 1, 3);
      step(1, '0, 1);
      expect_out("rst_dat", -1, 1, dir_dat(3), 1, 1, 3);
      step(1, '0, 1);
      expect_out("rst_done", -1, 0, 8'h00, 0, 0, 3);

      // Unit 7 pulses only while unit 2's frame is in flight.
      step(1, unit_vec(2), 1);
      expect_out("tog_grant", 2, 1, 8'h02, 1, 1, 2);
      step(1, unit_vec(7), 0);
      expect_out("tog_hold", -1, 1, 8'h02, 1, 1, 2);
      step(1, unit_vec(7), 1);
      expect_out("tog_hdr", -1, 1, dir_dat(2), 1, 1, 2);
      step(1, unit_vec(7), 1);
      expect_out("tog_dat", -1, 0, 8'h00, 0, 0, 2);
      step(1, '0, 1);
      expect_out("tog_idle0", -1, 0, 8'h00, 0, 0, 2);
      step(1, '0, 1);
      expect_out("tog_idle1", -1, 0, 8'h00, 0, 0, 2);

      // All units request at once after reset: headers must come out 0..N-1.
      do_reset();
      for (int i = 0; i < N; i++) pend[i] = 1;
      run_traffic(0, 1'b0, 3000);
      check("all_bytes", 256'(rx_log.size()), 256'(2 * N));
      for (int k = 0; k < N; k++) begin
         if (2 * k < rx_log.size()) check($sformatf("all_hdr%0d", k), 256'(rx_log[2*k]), 256'(k));
      end
      bad = 0;
      for (int i = 0; i < N; i++) if (ack_cnt[i] != 1) bad++;
      check("all_ack_once", 256'(bad), 256'(0));

      // Randomized arrivals and back-pressure against the frame-level model.
      do_reset();
      total = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = $urandom_range(0, 2);
         total += pend[i];
      end
      run_traffic(7, 1'b1, 40000);
      check("rand_bytes", 256'(rx_log.size()), 256'(2 * total));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
